// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-to-SRAM access sequencer: state encoding,
// default strobe length and the page-map validity rule.
package mem_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_CHECK  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ALARM  = 3'd5,
    ST_DRAIN  = 3'd6
  } state_t;

  // Default number of cycles the SRAM strobes stay asserted (legal 1..15)
  localparam int WAIT_CYCLES_DEFAULT = 2;

  // Page 0 is always backed by frame 0; any other page mapping to frame 0
  // has no memory behind it.
  function automatic logic is_unmapped(input logic [0:7] page_v,
                                       input logic [0:7] frame_v);
    return (frame_v == 8'h00) && (page_v != 8'h00);
  endfunction

endpackage

// File: rtl/mem_access.sv
// CPU memory access sequencer: latches a 4-phase request, translates the
// logical page through an external memory map, runs a fixed-length SRAM
// strobe and reports completion (ok) or an unmapped page (alarm).
module mem_access
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [0:3]  nb,
  input  logic [0:15] ad,
  input  logic [0:15] wdata,
  input  logic        cfg,
  output logic [0:7]  page,
  output logic        rd,
  input  logic [0:7]  frame,
  output logic [0:19] sram_addr,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we,
  output logic [0:15] sram_dout,
  input  logic [0:15] sram_din,
  output logic [0:15] rdata,
  output logic        ok,
  output logic        alarm
);

  localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];

  state_t      state_r;
  state_t      state_s;
  logic        accept_s;
  logic        last_access_s;
  logic [0:7]  page_s;

  logic        we_r;
  logic [0:3]  nb_r;
  logic [0:15] ad_r;
  logic [0:15] wdata_r;
  logic        arm_r;
  logic [3:0]  wait_cnt_r;
  logic [0:19] sram_addr_r;
  logic [0:15] rdata_r;
  logic        rd_r;
  logic        ce_r;
  logic        oe_r;
  logic        swe_r;
  logic        ok_r;
  logic        alarm_r;

  assign page_s        = {nb_r, ad_r[0:3]};
  assign accept_s      = (state_r == ST_IDLE) && (state_s == ST_LOOKUP);
  assign last_access_s = (state_r == ST_ACCESS) && (wait_cnt_r == 4'd1);

  // Next-state logic; dropping req never aborts a started access
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req && !cfg && arm_r) state_s = ST_LOOKUP;
        else                      state_s = ST_IDLE;
      end
      ST_LOOKUP: state_s = ST_CHECK;
      ST_CHECK: begin
        if (is_unmapped(page_s, frame)) begin
          if (req) state_s = ST_ALARM;
          else     state_s = ST_DRAIN;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_cnt_r == 4'd1) begin
          if (req) state_s = ST_DONE;
          else     state_s = ST_DRAIN;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        if (req) state_s = ST_DONE;
        else     state_s = ST_IDLE;
      end
      ST_ALARM: begin
        if (req) state_s = ST_ALARM;
        else     state_s = ST_IDLE;
      end
      ST_DRAIN: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Request latch: captured once when a request is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r    <= 1'b0;
      nb_r    <= 4'h0;
      ad_r    <= 16'h0000;
      wdata_r <= 16'h0000;
    end else if (accept_s) begin
      we_r    <= we;
      nb_r    <= nb;
      ad_r    <= ad;
      wdata_r <= wdata;
    end else begin
      we_r    <= we_r;
      nb_r    <= nb_r;
      ad_r    <= ad_r;
      wdata_r <= wdata_r;
    end
  end

  // Re-arm flag: a held req must be seen low in IDLE before it counts again
  always_ff @(posedge clk) begin
    if (reset)                              arm_r <= 1'b1;
    else if (accept_s)                      arm_r <= 1'b0;
    else if ((state_r == ST_IDLE) && !req)  arm_r <= 1'b1;
    else                                    arm_r <= arm_r;
  end

  // Strobe-length counter: loaded on entry to ACCESS, stops at 1
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt_r <= 4'd0;
    else if ((state_r == ST_CHECK) && (state_s == ST_ACCESS))
      wait_cnt_r <= WAIT_LOAD;
    else if ((state_r == ST_ACCESS) && (wait_cnt_r > 4'd1))
      wait_cnt_r <= wait_cnt_r - 4'd1;
    else
      wait_cnt_r <= wait_cnt_r;
  end

  // Physical address: frame latched in CHECK, held stable through ACCESS
  always_ff @(posedge clk) begin
    if (reset)
      sram_addr_r <= 20'h00000;
    else if ((state_r == ST_CHECK) && (state_s == ST_ACCESS))
      sram_addr_r <= {frame, ad_r[4:15]};
    else
      sram_addr_r <= sram_addr_r;
  end

  // Read data captured on the final strobe cycle of a read only
  always_ff @(posedge clk) begin
    if (reset)                      rdata_r <= 16'h0000;
    else if (last_access_s && !we_r) rdata_r <= sram_din;
    else                            rdata_r <= rdata_r;
  end

  // Registered control outputs; ok/alarm drop on the edge that sees req low
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_r    <= 1'b0;
      ce_r    <= 1'b0;
      oe_r    <= 1'b0;
      swe_r   <= 1'b0;
      ok_r    <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      rd_r    <= (state_s == ST_LOOKUP) || (state_s == ST_CHECK);
      ce_r    <= (state_s == ST_ACCESS);
      oe_r    <= (state_s == ST_ACCESS) && !we_r;
      swe_r   <= (state_s == ST_ACCESS) && we_r;
      ok_r    <= (state_r == ST_DONE) && req;
      alarm_r <= (state_r == ST_ALARM) && req;
    end
  end

  assign page      = page_s;
  assign rd        = rd_r;
  assign sram_addr = sram_addr_r;
  assign sram_ce   = ce_r;
  assign sram_oe   = oe_r;
  assign sram_we   = swe_r;
  assign sram_dout = wdata_r;
  assign rdata     = rdata_r;
  assign ok        = ok_r;
  assign alarm     = alarm_r;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: behavioural memory map and SRAM,
// directed scenarios plus randomized transactions against a reference model.
module tb_mem_access;

  localparam int W   = 2;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset, req, we, cfg;
  logic [3:0]  nb;
  logic [15:0] ad, wdata;
  logic [7:0]  page, frame;
  logic        rd;
  logic [19:0] sram_addr;
  logic        sram_ce, sram_oe, sram_we;
  logic [15:0] sram_dout, sram_din, rdata;
  logic        ok, alarm;

  bit   [7:0]  map_mem  [0:255];
  bit   [15:0] sram_mem [0:1048575];
  logic        pre_we;
  logic [19:0] pre_addr;
  logic [15:0] pre_data;

  logic [15:0] ref_mem [int];
  logic [15:0] exp_rdata;
  int          n_checks, n_fail;

  int   r_lat_ok, r_lat_alarm, r_ce, r_oe, r_we, r_rd;
  logic r_rd_bad, r_addr_stable, r_both, r_ok_after, r_alarm_after, r_timeout;
  logic [19:0] r_addr;

  mem_access #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .nb(nb), .ad(ad),
    .wdata(wdata), .cfg(cfg), .page(page), .rd(rd), .frame(frame),
    .sram_addr(sram_addr), .sram_ce(sram_ce), .sram_oe(sram_oe),
    .sram_we(sram_we), .sram_dout(sram_dout), .sram_din(sram_din),
    .rdata(rdata), .ok(ok), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Memory map: frame valid one clock after page is presented
  always @(posedge clk) frame <= map_mem[page];

  // Asynchronous-read SRAM with a bench preload port
  assign sram_din = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (pre_we) sram_mem[pre_addr] <= pre_data;
    else if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_dout;
  end

  // Reference model helpers
  function automatic logic [7:0] m_page(input logic [3:0] b, input logic [15:0] a);
    return {b, a[15:12]};
  endfunction
  function automatic logic m_mapped(input logic [7:0] p);
    return (p == 8'h00) || (map_mem[p] != 8'h00);
  endfunction
  function automatic logic [19:0] m_phys(input logic [7:0] p, input logic [15:0] a);
    return {map_mem[p], a[11:0]};
  endfunction
  function automatic logic [15:0] m_read(input logic [19:0] pa);
    if (ref_mem.exists(int'(pa))) return ref_mem[int'(pa)];
    else return 16'h0000;
  endfunction

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  // Runs one request and records what the bus did; drop_at<0 holds req until ok/alarm
  task automatic drive_txn(input logic t_we, input logic [3:0] t_nb,
                           input logic [15:0] t_ad, input logic [15:0] t_wd,
                           input int drop_at);
    r_lat_ok = -1; r_lat_alarm = -1; r_ce = 0; r_oe = 0; r_we = 0; r_rd = 0;
    r_rd_bad = 1'b0; r_addr_stable = 1'b1; r_both = 1'b0; r_addr = 20'h0;
    r_ok_after = 1'b0; r_alarm_after = 1'b0; r_timeout = 1'b0;
    @(posedge clk); #1;
    we = t_we; nb = t_nb; ad = t_ad; wdata = t_wd; req = 1'b1;
    for (int n = 0; n < TMO; n++) begin
      @(posedge clk); @(negedge clk);
      if (sram_ce) begin
        if (r_ce == 0) r_addr = sram_addr;
        else if (sram_addr !== r_addr) r_addr_stable = 1'b0;
        r_ce++;
      end
      if (sram_oe) r_oe++;
      if (sram_we) r_we++;
      if (ok && alarm) r_both = 1'b1;
      if (rd) begin
        if (n < 2) r_rd++;
        else r_rd_bad = 1'b1;
      end
      if (ok && r_lat_ok < 0) r_lat_ok = n;
      if (alarm && r_lat_alarm < 0) r_lat_alarm = n;
      if (n == drop_at) req = 1'b0;
      if (drop_at < 0 && (r_lat_ok >= 0 || r_lat_alarm >= 0)) begin
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        r_ok_after = ok; r_alarm_after = alarm;
        break;
      end
      if (drop_at >= 0 && n >= W + 6) break;
      if (n == TMO - 1 && drop_at < 0) r_timeout = 1'b1;
    end
    req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    int lat;
    logic acc;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ok, alarm, rd, sram_ce, sram_oe, sram_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 000000", {ok, alarm, rd, sram_ce, sram_oe, sram_we});
    end
    n_checks++;
    if ({rdata, page, sram_addr, sram_dout} !== 60'h0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h page=%h addr=%h dout=%h expected all 0", rdata, page, sram_addr, sram_dout);
    end
    // request present as reset releases: page 0 with frame 0 is legal
    map_mem[0] = 8'h00;
    reset = 1'b0; req = 1'b1; we = 1'b0; nb = 4'h0; ad = 16'h0123;
    lat = -1; acc = 1'b0;
    for (int n = 0; n < TMO; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 0) acc = rd;
      if (ok) begin lat = n; break; end
    end
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL first_accept: rd=%b expected 1", acc); end
    n_checks++;
    if (lat != 3 + W) begin n_fail++; $display("FAIL page0_latency: got %0d expected %0d", lat, 3 + W); end
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (ok !== 1'b0) begin n_fail++; $display("FAIL page0_release: ok=%b expected 0", ok); end
    exp_rdata = m_read(20'h00123);
    @(posedge clk);
  endtask

  task automatic test_read();
    preload(20'h05ABC, 16'h1234);
    map_mem[8'h23] = 8'h05;
    drive_txn(1'b0, 4'h2, 16'h3ABC, 16'h0000, -1);
    exp_rdata = 16'h1234;
    n_checks++;
    if (r_timeout || r_lat_ok != 3 + W) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", r_lat_ok, 3 + W); end
    n_checks++;
    if (rdata !== exp_rdata) begin n_fail++; $display("FAIL read_data: got %h expected %h", rdata, exp_rdata); end
    n_checks++;
    if (r_addr !== 20'h05ABC || !r_addr_stable) begin n_fail++; $display("FAIL read_addr: got %h stable=%b expected 05abc", r_addr, r_addr_stable); end
    n_checks++;
    if (r_ce != W || r_oe != W || r_we != 0) begin n_fail++; $display("FAIL read_strobes: ce=%0d oe=%0d we=%0d expected %0d %0d 0", r_ce, r_oe, r_we, W, W); end
    n_checks++;
    if (r_rd != 2 || r_rd_bad) begin n_fail++; $display("FAIL read_rd: cycles=%0d stray=%b expected 2 0", r_rd, r_rd_bad); end
    n_checks++;
    if (r_ok_after !== 1'b0) begin n_fail++; $display("FAIL read_release: ok=%b expected 0", r_ok_after); end
  endtask

  task automatic test_write();
    map_mem[8'h01] = 8'h01;
    drive_txn(1'b1, 4'h0, 16'h1007, 16'hBEEF, -1);
    ref_mem[int'(20'h01007)] = 16'hBEEF;
    n_checks++;
    if (r_timeout || r_lat_ok != 3 + W) begin n_fail++; $display("FAIL write_latency: got %0d expected %0d", r_lat_ok, 3 + W); end
    n_checks++;
    if (r_we != W || r_oe != 0 || r_addr !== 20'h01007) begin n_fail++; $display("FAIL write_strobes: we=%0d oe=%0d addr=%h expected %0d 0 01007", r_we, r_oe, r_addr, W); end
    n_checks++;
    if (sram_mem[20'h01007] !== 16'hBEEF) begin n_fail++; $display("FAIL write_mem: got %h expected beef", sram_mem[20'h01007]); end
    n_checks++;
    if (rdata !== exp_rdata) begin n_fail++; $display("FAIL write_rdata: got %h expected %h", rdata, exp_rdata); end
  endtask

  task automatic test_unmapped();
    map_mem[8'h40] = 8'h00;
    drive_txn(1'b0, 4'h4, 16'h0555, 16'h0000, -1);
    n_checks++;
    if (r_timeout || r_lat_alarm != 3 || r_lat_ok != -1) begin n_fail++; $display("FAIL alarm_latency: alarm=%0d ok=%0d expected 3 -1", r_lat_alarm, r_lat_ok); end
    n_checks++;
    if (r_ce != 0 || r_oe != 0 || r_we != 0) begin n_fail++; $display("FAIL alarm_strobes: ce=%0d oe=%0d we=%0d expected 0", r_ce, r_oe, r_we); end
    n_checks++;
    if (r_alarm_after !== 1'b0 || r_both) begin n_fail++; $display("FAIL alarm_release: alarm=%b both=%b expected 0 0", r_alarm_after, r_both); end
    n_checks++;
    if (rdata !== exp_rdata) begin n_fail++; $display("FAIL alarm_rdata: got %h expected %h", rdata, exp_rdata); end
  endtask

  task automatic test_cfg();
    logic stayed, acc;
    int lat;
    @(posedge clk); #1;
    cfg = 1'b1; req = 1'b1; we = 1'b0; nb = 4'h2; ad = 16'h3ABC;
    stayed = 1'b1;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (rd || sram_ce || ok || alarm) stayed = 1'b0;
    end
    n_checks++;
    if (stayed !== 1'b1) begin n_fail++; $display("FAIL cfg_block: idle=%b expected 1", stayed); end
    cfg = 1'b0;
    lat = -1; acc = 1'b0;
    for (int n = 0; n < TMO; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 0) acc = rd;
      if (ok) begin lat = n; break; end
    end
    n_checks++;
    if (acc !== 1'b1 || lat != 3 + W) begin n_fail++; $display("FAIL cfg_accept: rd=%b lat=%0d expected 1 %0d", acc, lat, 3 + W); end
    exp_rdata = m_read(20'h05ABC);
    n_checks++;
    if (rdata !== exp_rdata) begin n_fail++; $display("FAIL cfg_data: got %h expected %h", rdata, exp_rdata); end
    req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; nb = 4'h2; ad = 16'h3ABC;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sram_ce !== 1'b1) begin n_fail++; $display("FAIL mid_access_ce: got %b expected 1", sram_ce); end
    reset = 1'b1; req = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({sram_ce, sram_oe, sram_we, rd, ok, alarm} !== 6'b0 || rdata !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset: ctl=%b rdata=%h expected 000000 0000", {sram_ce, sram_oe, sram_we, rd, ok, alarm}, rdata);
    end
    reset = 1'b0;
    exp_rdata = 16'h0000;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (ok || rd || sram_ce) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle: activity=%b expected 0", seen); end
    drive_txn(1'b0, 4'h2, 16'h3ABC, 16'h0000, -1);
    exp_rdata = m_read(20'h05ABC);
    n_checks++;
    if (r_timeout || r_lat_ok != 3 + W || rdata !== exp_rdata) begin
      n_fail++; $display("FAIL after_reset_read: lat=%0d rdata=%h expected %0d %h", r_lat_ok, rdata, 3 + W, exp_rdata);
    end
  endtask

  task automatic test_drop_early();
    drive_txn(1'b1, 4'h0, 16'h1008, 16'hCAFE, 0);
    ref_mem[int'(20'h01008)] = 16'hCAFE;
    n_checks++;
    if (r_lat_ok != -1 || r_lat_alarm != -1) begin n_fail++; $display("FAIL drop_no_ok: ok=%0d alarm=%0d expected -1 -1", r_lat_ok, r_lat_alarm); end
    n_checks++;
    if (r_we != W || sram_mem[20'h01008] !== 16'hCAFE) begin n_fail++; $display("FAIL drop_write: we=%0d mem=%h expected %0d cafe", r_we, sram_mem[20'h01008], W); end
    drive_txn(1'b0, 4'h0, 16'h1008, 16'h0000, -1);
    exp_rdata = m_read(20'h01008);
    n_checks++;
    if (r_timeout || r_lat_ok != 3 + W || rdata !== exp_rdata) begin
      n_fail++; $display("FAIL drop_next: lat=%0d rdata=%h expected %0d %h", r_lat_ok, rdata, 3 + W, exp_rdata);
    end
  endtask

  task automatic test_no_rearm();
    logic idle, acc;
    int lat;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; nb = 4'h2; ad = 16'h3ABC;
    for (int n = 0; n < TMO; n++) begin
      @(posedge clk); @(negedge clk);
      if (ok) break;
    end
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    req = 1'b1;
    idle = 1'b1;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (rd || sram_ce) idle = 1'b0;
    end
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL held_req_ignored: idle=%b expected 1", idle); end
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    req = 1'b1;
    lat = -1; acc = 1'b0;
    for (int n = 0; n < TMO; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 0) acc = rd;
      if (ok) begin lat = n; break; end
    end
    n_checks++;
    if (acc !== 1'b1 || lat != 3 + W) begin n_fail++; $display("FAIL rearm_accept: rd=%b lat=%0d expected 1 %0d", acc, lat, 3 + W); end
    exp_rdata = m_read(20'h05ABC);
    req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    logic        t_we, mp;
    logic [3:0]  t_nb;
    logic [15:0] t_ad, t_wd;
    logic [7:0]  p;
    logic [19:0] pa;
    for (int i = 0; i < 256; i++)
      map_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int k = 0; k < 30; k++) begin
      t_we = 1'($urandom_range(0, 1));
      t_nb = 4'($urandom_range(0, 3));
      t_ad = {4'($urandom_range(0, 3)), 12'($urandom_range(0, 3) * 273)};
      t_wd = 16'($urandom);
      p  = m_page(t_nb, t_ad);
      mp = m_mapped(p);
      pa = m_phys(p, t_ad);
      drive_txn(t_we, t_nb, t_ad, t_wd, -1);
      n_checks++;
      if (r_timeout || r_both) begin n_fail++; $display("FAIL rnd_handshake[%0d]: timeout=%b both=%b", k, r_timeout, r_both); end
      if (mp) begin
        if (!t_we) exp_rdata = m_read(pa);
        n_checks++;
        if (r_lat_ok != 3 + W || r_lat_alarm != -1) begin n_fail++; $display("FAIL rnd_latency[%0d]: ok=%0d alarm=%0d expected %0d -1", k, r_lat_ok, r_lat_alarm, 3 + W); end
        n_checks++;
        if (r_addr !== pa || !r_addr_stable || r_ce != W) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h ce=%0d expected %h %0d", k, r_addr, r_ce, pa, W); end
        n_checks++;
        if (r_we != (t_we ? W : 0) || r_oe != (t_we ? 0 : W)) begin n_fail++; $display("FAIL rnd_dir[%0d]: we=%0d oe=%0d for we=%b", k, r_we, r_oe, t_we); end
        if (t_we) ref_mem[int'(pa)] = t_wd;
      end else begin
        n_checks++;
        if (r_lat_alarm != 3 || r_lat_ok != -1 || r_ce != 0) begin n_fail++; $display("FAIL rnd_alarm[%0d]: alarm=%0d ok=%0d ce=%0d expected 3 -1 0", k, r_lat_alarm, r_lat_ok, r_ce); end
      end
      n_checks++;
      if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", k, rdata, exp_rdata); end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; req = 1'b0; we = 1'b0; cfg = 1'b0; nb = 4'h0;
    ad = 16'h0000; wdata = 16'h0000; exp_rdata = 16'h0000;
    pre_we = 1'b0; pre_addr = 20'h0; pre_data = 16'h0;
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_cfg();
    test_reset_mid_access();
    test_drop_early();
    test_no_rearm();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: SRAM strobe cycles per access, legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 req  input  1  CPU memory request; 4-phase, held until ok or alarm seen.
REQ-005 we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 nb  input  [0:3]  block number.
REQ-007 ad  input  [0:15]  logical word address.
REQ-008 wdata  input  [0:15]  write data.
REQ-009 cfg  input  1  memory-configuration cycle in progress; blocks new requests.
REQ-010 page  output  [0:7]  page to memory map = {nb, ad[0:3]} of latched request.
REQ-011 rd  output  1  memory map read enable.
REQ-012 frame  input  [0:7]  map output; valid one clock after page is presented.
REQ-013 sram_addr  output  [0:19]  physical address = {frame, ad[4:15]}.
REQ-014 sram_ce, sram_oe, sram_we  output  1 each  active-high SRAM strobes.
REQ-015 sram_dout  output  [0:16-1]  write data to SRAM; sram_din  input  [0:15]  read data.
REQ-016 rdata  output  [0:15]  read result; ok  output  1  completion; alarm  output  1  no-memory.

Function
REQ-017 States: IDLE, LOOKUP, CHECK, ACCESS, DONE, ALARM, DRAIN.
REQ-018 IDLE: req=1 and cfg=0 -> latch we, nb, ad, wdata; go LOOKUP; req ignored while cfg=1.
REQ-019 LOOKUP: page driven from latch, rd=1, one cycle; go CHECK.
REQ-020 CHECK: rd=1; latch frame; frame=0 with page!=0 -> ALARM, else load wait counter, go ACCESS.
REQ-021 ACCESS: sram_ce=1 for exactly WAIT_CYCLES cycles; sram_oe=~we, sram_we=we; sram_addr and sram_dout stable whole state.
REQ-022 Read data captured into rdata on last ACCESS cycle; rdata unchanged by writes and alarms.
REQ-023 DONE: ok=1, held until req=0, then IDLE.
REQ-024 ALARM: alarm=1, no SRAM strobe ever asserted, held until req=0, then IDLE.
REQ-025 Latency: req sampled at edge T0 -> ok first high after edge T0+3+WAIT_CYCLES (T0+5 at default).
REQ-026 req dropped before DONE/ALARM: started SRAM access completes uninterrupted; then DRAIN for one cycle with ok=0, alarm=0; then IDLE.
REQ-027 req still high on return to IDLE is not a new request; new request requires req=0 seen in IDLE first.
REQ-028 page=0 always legal (frame 0 valid); only frame=0 with page!=0 is unmapped.
REQ-029 rd=0 outside LOOKUP/CHECK; ok and alarm never high together.
REQ-030 Wait counter 4 bits, counts down to 1, no wrap.

Reset
REQ-031 reset=1 at an edge -> state IDLE; ok, alarm, rd, sram_ce, sram_oe, sram_we = 0; rdata=0; latches=0; takes priority over all transitions, including mid-ACCESS.
REQ-032 First request accepted at the first edge after reset deasserts.

Structure
REQ-033 State encoding and WAIT_CYCLES default in shared package mem_pkg.
REQ-034 Single module; wait counter inline; no sub-module.

Verification
REQ-035 Read: map page 0x23->frame 0x05, SRAM[0x05ABC]=0x1234; req, nb=2, ad=0x3ABC, we=0 -> ok at T0+5, rdata=0x1234, sram_addr=0x05ABC.
REQ-036 Write: page 0x01->frame 0x01, req, we=1, ad=0x1007, wdata=0xBEEF -> sram_we high 2 cycles at addr 0x01007, ok at T0+5, SRAM[0x01007]=0xBEEF.
REQ-037 Unmapped: page 0x40 frame 0 -> alarm at T0+3, sram_ce never high, alarm clears cycle after req=0.
REQ-038 cfg=1 with req=1 for 10 cycles -> stays IDLE; cfg drops -> request accepted next edge.
REQ-039 reset asserted during second ACCESS cycle -> all strobes 0 next edge, state IDLE, ok never asserted.
REQ-040 req dropped in LOOKUP of a write -> write completes, DRAIN one cycle, no ok, next request served normally.
